axi_read_w2n_width_converter: RTL

AXI_READ_W2N_WIDTH_CONVERTER -- requirements
Module: axi_read_w2n_width_converter
Interface
REQ-001 SHALL have parameter SOURCE_WIDTH, default 64, upstream (s_axi) narrow read data width in bits.
REQ-002 SHALL have parameter TARGET_WIDTH, default 128, downstream (m_axi) wide read data width in bits; R = TARGET_WIDTH/SOURCE_WIDTH, a power of two >= 2.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, address width in bits.
REQ-004 aclk  input  1  single clock; all logic on rising edge.
REQ-005 areset  input  1  reset, synchronous, active-high.
REQ-006 s_axi_araddr  input  ADDR_WIDTH  upstream read address.
REQ-007 s_axi_arsize  input  3  upstream beat size.
REQ-008 s_axi_arlen  input  8  upstream beats minus one.
REQ-009 s_axi_arburst  input  2  upstream burst type.
REQ-010 s_axi_arid  input  8  upstream transaction ID.
REQ-011 s_axi_arvalid  input  1  upstream AR valid.
REQ-012 s_axi_arready  output  1  upstream AR ready.
REQ-013 s_axi_rdata  output  SOURCE_WIDTH  narrow read data.
REQ-014 s_axi_rid  output  8  read ID, equal to captured arid.
REQ-015 s_axi_rresp  output  2  read response.
REQ-016 s_axi_rvalid  output  1  narrow beat valid.
REQ-017 s_axi_rready  input  1  narrow beat ready.
REQ-018 s_axi_rlast  output  1  last narrow beat.
REQ-019 m_axi_araddr  output  ADDR_WIDTH  wide-aligned address.
REQ-020 m_axi_arsize  output  3  log2(TARGET_WIDTH/8).
REQ-021 m_axi_arlen  output  8  wide beats minus one.
REQ-022 m_axi_arburst  output  2  constant INCR (2'b01).
REQ-023 m_axi_arid  output  8  captured arid.
REQ-024 m_axi_arvalid  output  1  downstream AR valid.
REQ-025 m_axi_arready  input  1  downstream AR ready.
REQ-026 m_axi_rdata  input  TARGET_WIDTH  wide read data; m_axi_rresp input 2; m_axi_rvalid input 1; m_axi_rready output 1; downstream rid/rlast not used.
Function
REQ-027 FSM states IDLE, ADDR, DATA, ERR; one transaction outstanding; s_axi_arready=1 only in IDLE.
REQ-028 IDLE: on s_axi_arvalid&&s_axi_arready capture addr/len/id, lane0 = araddr[log2(TARGET_WIDTH/8)-1 : log2(SOURCE_WIDTH/8)], go ADDR.
REQ-029 ADDR: m_axi_arvalid=1, m_axi_araddr = captured addr with low log2(TARGET_WIDTH/8) bits zeroed, m_axi_arlen = (lane0 + arlen) >> log2(R); hold stable until m_axi_arready, then DATA.
REQ-030 DATA: one TARGET_WIDTH holding register plus valid flag; m_axi_rready = !hold_valid; capture rdata/rresp on m_axi_rvalid&&m_axi_rready.
REQ-031 s_axi_rvalid = hold_valid; s_axi_rdata = lane slice [lane*SOURCE_WIDTH +: SOURCE_WIDTH]; s_axi_rresp = held rresp; first narrow beat valid the cycle after wide capture.
REQ-032 Per narrow handshake: beat counter +1, lane +1; hold_valid clears when lane==R-1 or last beat, lane wraps to 0.
REQ-033 s_axi_rlast = (beat counter == captured arlen); after its handshake go IDLE, hold cleared; rvalid/rlast held stable while s_axi_rready=0.
REQ-034 Worst-case throughput: one narrow beat per cycle; one bubble cycle per wide-beat refill.
Reset
REQ-035 On areset: state IDLE; s_axi_arready, s_axi_rvalid, s_axi_rlast, m_axi_arvalid, m_axi_rready = 0; counters, lane, hold_valid, captured fields = 0; s_axi_arready rises the first cycle after areset deasserts.
REQ-036 areset mid-burst SHALL abandon the transaction and discard the held beat; no further rvalid until a new AR.
Configuration
REQ-037 Macro AXI_R_W2N_ERR_CHECK_EN defined: AR with arburst!=INCR or arsize!=log2(SOURCE_WIDTH/8) goes to ERR, no m_axi AR issued; ERR returns arlen+1 beats, rdata=0, rresp=SLVERR (2'b10), rlast on final beat, then IDLE.
REQ-038 Macro undefined: no ERR state; every AR converted per REQ-028..033 regardless of arburst/arsize.
Verification
REQ-039 AR addr=0x100 len=3 size=3, wide beats A,B -> m_axi_arlen=1, araddr=0x100; s_axi_rdata A[63:0],A[127:64],B[63:0],B[127:64]; rlast on 4th.
REQ-040 AR addr=0x108 len=2 -> m_axi_araddr=0x100, arlen=1; first beat A[127:64]; rlast on 3rd.
REQ-041 s_axi_rready toggled 1,0,0,1 during burst -> rdata/rvalid stable while low; no wide beat lost; m_axi_rready low while hold full.
REQ-042 areset pulsed after 2 of 8 beats -> rvalid=0 next cycle; new AR len=0 completes normally; with AXI_R_W2N_ERR_CHECK_EN, AR arburst=FIXED len=1 -> 2 SLVERR beats, m_axi_arvalid never 1.

---
 rtl/axi_read_w2n_width_converter.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_read_w2n_width_converter.sv
// AXI read-channel width converter: a wide (TARGET_WIDTH) downstream read
// port feeding a narrow (SOURCE_WIDTH) upstream master. Each upstream AR is
// converted to a single wide-aligned INCR burst. Every returned wide beat is
// parked in a holding register and unpacked lane by lane into narrow beats.
// One transaction is outstanding at a time.
//
// Optional build macro AXI_R_W2N_ERR_CHECK_EN: upstream requests with a burst
// type other than INCR, or a beat size other than the narrow bus width, are
// not forwarded. Instead they are answered locally with arlen+1 SLVERR beats.
module axi_read_w2n_width_converter #(
    parameter int SOURCE_WIDTH = 64,
    parameter int TARGET_WIDTH = 128,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                    aclk,
    input  logic                    areset,
    // upstream (narrow) read address channel
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]              s_axi_arsize,
    input  logic [7:0]              s_axi_arlen,
    input  logic [1:0]              s_axi_arburst,
    input  logic [7:0]              s_axi_arid,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    // upstream (narrow) read data channel
    output logic [SOURCE_WIDTH-1:0] s_axi_rdata,
    output logic [7:0]              s_axi_rid,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic                    s_axi_rlast,
    // downstream (wide) read address channel
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arsize,
    output logic [7:0]              m_axi_arlen,
    output logic [1:0]              m_axi_arburst,
    output logic [7:0]              m_axi_arid,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    // downstream (wide) read data channel
    input  logic [TARGET_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam int R        = TARGET_WIDTH / SOURCE_WIDTH;
    localparam int LANE_W   = $clog2(R);
    localparam int T_BYTE_W = $clog2(TARGET_WIDTH / 8);
    localparam int S_BYTE_W = $clog2(SOURCE_WIDTH / 8);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(R - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
`ifdef AXI_R_W2N_ERR_CHECK_EN
        ,
        ERR  = 2'd3
`endif
    } state_t;

    state_t                  state_reg;
    logic                    arready_reg;
    logic                    m_arvalid_reg;
    logic [ADDR_WIDTH-1:0]   m_araddr_reg;
    logic [7:0]              m_arlen_reg;
    logic [7:0]              id_reg;
    logic [7:0]              len_reg;
    logic [7:0]              beat_reg;
    logic [LANE_W-1:0]       lane_reg;
    logic [TARGET_WIDTH-1:0] hold_reg;
    logic [1:0]              hold_resp_reg;
    logic                    hold_valid_reg;

    // Starting lane inside the first wide word, and the wide beat count it implies
    logic [LANE_W-1:0]       lane0_next;
    logic [8:0]              narrow_span_next;
    logic [7:0]              wide_len_next;
    logic [ADDR_WIDTH-1:0]   aligned_addr_next;
    logic                    wide_fire;
    logic                    narrow_fire;

    assign lane0_next        = s_axi_araddr[T_BYTE_W-1:S_BYTE_W];
    assign narrow_span_next  = {1'b0, s_axi_arlen} + 9'(lane0_next);
    assign wide_len_next     = 8'(narrow_span_next >> LANE_W);
    assign aligned_addr_next = {s_axi_araddr[ADDR_WIDTH-1:T_BYTE_W], T_BYTE_W'(0)};

    assign wide_fire   = m_axi_rvalid && m_axi_rready;
    assign narrow_fire = s_axi_rvalid && s_axi_rready;

    // Lane slices of the holding register, selected by the current lane
    logic [SOURCE_WIDTH-1:0] lane_slice [R];

    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_lane
            assign lane_slice[gi] = hold_reg[gi*SOURCE_WIDTH +: SOURCE_WIDTH];
        end
    endgenerate

    // Downstream AR channel: registered fields, burst shape fixed to wide INCR
    assign s_axi_arready = arready_reg;
    assign m_axi_arvalid = m_arvalid_reg;
    assign m_axi_araddr  = m_araddr_reg;
    assign m_axi_arlen   = m_arlen_reg;
    assign m_axi_arid    = id_reg;
    assign m_axi_arsize  = 3'(T_BYTE_W);
    assign m_axi_arburst = 2'b01;

    // Only pull a new wide beat once the previous one has been fully unpacked
    assign m_axi_rready  = (state_reg == DATA) && !hold_valid_reg;

    assign s_axi_rid     = id_reg;
    assign s_axi_rlast   = s_axi_rvalid && (beat_reg == len_reg);

`ifdef AXI_R_W2N_ERR_CHECK_EN
    logic err_active;
    logic req_bad;

    assign err_active   = (state_reg == ERR);
    assign req_bad      = (s_axi_arburst != 2'b01) || (s_axi_arsize != 3'(S_BYTE_W));
    assign s_axi_rvalid = hold_valid_reg || err_active;
    assign s_axi_rdata  = err_active ? '0 : lane_slice[lane_reg];
    assign s_axi_rresp  = err_active ? 2'b10 : hold_resp_reg;
`else
    // Burst type and beat size are taken on trust in this build
    logic unused_ar_fields;

    assign unused_ar_fields = ^{s_axi_arsize, s_axi_arburst};
    assign s_axi_rvalid     = hold_valid_reg;
    assign s_axi_rdata      = lane_slice[lane_reg];
    assign s_axi_rresp      = hold_resp_reg;
`endif

    // Transaction FSM: address capture, wide AR issue, lane-by-lane unpacking
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg      <= IDLE;
            arready_reg    <= 1'b0;
            m_arvalid_reg  <= 1'b0;
            m_araddr_reg   <= '0;
            m_arlen_reg    <= '0;
            id_reg         <= '0;
            len_reg        <= '0;
            beat_reg       <= '0;
            lane_reg       <= '0;
            hold_reg       <= '0;
            hold_resp_reg  <= '0;
            hold_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    arready_reg <= 1'b1;
                    if (s_axi_arvalid && arready_reg) begin
                        arready_reg  <= 1'b0;
                        id_reg       <= s_axi_arid;
                        len_reg      <= s_axi_arlen;
                        beat_reg     <= '0;
                        lane_reg     <= lane0_next;
                        m_araddr_reg <= aligned_addr_next;
                        m_arlen_reg  <= wide_len_next;
`ifdef AXI_R_W2N_ERR_CHECK_EN
                        if (req_bad) begin
                            state_reg <= ERR;
                        end else begin
                            m_arvalid_reg <= 1'b1;
                            state_reg     <= ADDR;
                        end
`else
                        m_arvalid_reg <= 1'b1;
                        state_reg     <= ADDR;
`endif
                    end
                end

                ADDR: begin
                    if (m_axi_arready) begin
                        m_arvalid_reg <= 1'b0;
                        state_reg     <= DATA;
                    end
                end

                DATA: begin
                    if (wide_fire) begin
                        hold_reg       <= m_axi_rdata;
                        hold_resp_reg  <= m_axi_rresp;
                        hold_valid_reg <= 1'b1;
                    end
                    if (narrow_fire) begin
                        if (s_axi_rlast) begin
                            hold_valid_reg <= 1'b0;
                            lane_reg       <= '0;
                            beat_reg       <= '0;
                            arready_reg    <= 1'b1;
                            state_reg      <= IDLE;
                        end else begin
                            beat_reg <= beat_reg + 8'd1;
                            if (lane_reg == LAST_LANE) begin
                                hold_valid_reg <= 1'b0;
                                lane_reg       <= '0;
                            end else begin
                                lane_reg <= lane_reg + 1'b1;
                            end
                        end
                    end
                end

`ifdef AXI_R_W2N_ERR_CHECK_EN
                ERR: begin
                    if (narrow_fire) begin
                        if (s_axi_rlast) begin
                            beat_reg    <= '0;
                            lane_reg    <= '0;
                            arready_reg <= 1'b1;
                            state_reg   <= IDLE;
                        end else begin
                            beat_reg <= beat_reg + 8'd1;
                        end
                    end
                end
`endif

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
